// File: rtl/sccb_pkg.sv
// State encoding and per-phase tick counts shared by the SCCB configuration sequencer.
package sccb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STRT,
    BYTE,
    ACK,
    STOP,
    GAP,
    FIN
  } sccb_state_t;

  localparam int STRT_TICKS = 2;
  localparam int BIT_TICKS  = 4;  // also the length of the ACK slot
  localparam int STOP_TICKS = 3;
  localparam int NUM_BYTES  = 3;  // device address, register address, register data

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick generator: one-cycle tick every CLK_DIV cycles while enabled.
// Counter is held at zero whenever the enable is low, so the first tick lands CLK_DIV cycles after enable rises.
module sccb_tick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/sccb_cfg_seq.sv
// SCCB configuration sequencer: writes NUM_REGS table entries as 3-byte SCCB frames, one per register.
// Optional macro SCCB_ACK_CHECK_EN: a NACK sets ERROR, finishes the ACK slot, sends STOP and aborts the run.
module sccb_cfg_seq
  import sccb_pkg::*;
#(
  parameter int         CLK_DIV   = 125,
  parameter logic [7:0] DEV_ADDR  = 8'h42,
  parameter int         NUM_REGS  = 64,
  parameter int         GAP_TICKS = 8
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  output logic [7:0] TBL_IDX,
  input  logic [7:0] TBL_ADDR,
  input  logic [7:0] TBL_DATA,
  output logic       SCL_O,
  output logic       SDA_OE,
  input  logic       SDA_I,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR
);

  localparam logic [7:0]  LAST_IDX  = 8'(NUM_REGS - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_TICKS - 1);
  localparam logic [15:0] STRT_LAST = 16'(STRT_TICKS - 1);
  localparam logic [15:0] BIT_LAST  = 16'(BIT_TICKS - 1);
  localparam logic [15:0] STOP_LAST = 16'(STOP_TICKS - 1);
  localparam logic [1:0]  BYTE_LAST = 2'(NUM_BYTES - 1);

  sccb_state_t state_q, state_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [1:0]  byte_q, byte_d;
  logic [7:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic        ld_q;
  logic [7:0]  addr_q, data_q;
  logic [7:0]  cur_byte;
  logic        cur_bit;
  logic        tick;
  logic        nack;

`ifdef SCCB_ACK_CHECK_EN
  assign nack = SDA_I;
`else
  logic unused_sda;
  assign unused_sda = SDA_I;
  assign nack       = 1'b0;
`endif

  assign BUSY    = (state_q != IDLE) && (state_q != FIN);
  assign DONE    = (state_q == FIN);
  assign ERROR   = err_q;
  assign TBL_IDX = idx_q;

  sccb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (CLOCK),
    .rst    (RESET),
    .enable (BUSY),
    .tick   (tick)
  );

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = DEV_ADDR;
      2'd1:    cur_byte = addr_q;
      default: cur_byte = data_q;
    endcase
  end

  assign cur_bit = cur_byte[3'd7 - bcnt_q];

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    err_d   = err_q;
    SCL_O   = 1'b1;
    SDA_OE  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = STRT;
          tcnt_d  = '0;
          bcnt_d  = '0;
          byte_d  = '0;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      STRT: begin
        SDA_OE = 1'b1;
        SCL_O  = (tcnt_q == 16'd0);
        if (tick) begin
          tcnt_d = tcnt_q + 16'd1;
          if (tcnt_q == STRT_LAST) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            byte_d  = '0;
            state_d = BYTE;
          end
        end
      end
      BYTE: begin
        SDA_OE = ~cur_bit;
        SCL_O  = (tcnt_q == 16'd1) || (tcnt_q == 16'd2);
        if (tick) begin
          tcnt_d = tcnt_q + 16'd1;
          if (tcnt_q == BIT_LAST) begin
            tcnt_d = '0;
            if (bcnt_q == 3'd7) begin
              state_d = ACK;
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end
        end
      end
      ACK: begin
        SCL_O = (tcnt_q == 16'd1) || (tcnt_q == 16'd2);
        if (tick) begin
          tcnt_d = tcnt_q + 16'd1;
          // SDA_I is sampled at the end of the SCL-high window
          if ((tcnt_q == 16'd2) && nack) begin
            err_d = 1'b1;
          end
          if (tcnt_q == BIT_LAST) begin
            tcnt_d = '0;
            bcnt_d = '0;
            if (err_q || (byte_q == BYTE_LAST)) begin
              state_d = STOP;
            end else begin
              byte_d  = byte_q + 2'd1;
              state_d = BYTE;
            end
          end
        end
      end
      STOP: begin
        SDA_OE = (tcnt_q != 16'd2);
        SCL_O  = (tcnt_q != 16'd0);
        if (tick) begin
          tcnt_d = tcnt_q + 16'd1;
          if (tcnt_q == STOP_LAST) begin
            tcnt_d  = '0;
            state_d = err_q ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        if (tick) begin
          tcnt_d = tcnt_q + 16'd1;
          if (tcnt_q == GAP_LAST) begin
            tcnt_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = FIN;
            end else begin
              idx_d   = idx_q + 8'd1;
              state_d = STRT;
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      tcnt_q <= '0;
      bcnt_q <= '0;
      byte_q <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
      ld_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      bcnt_q <= bcnt_d;
      byte_q <= byte_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
      // Table lookup settles one cycle after TBL_IDX moves, so capture on the cycle after STRT entry
      ld_q   <= (state_d == STRT) && (state_q != STRT);
      if (ld_q) begin
        addr_q <= TBL_ADDR;
        data_q <= TBL_DATA;
      end
    end
  end

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// Directed bench for sccb_cfg_seq: a bus decoder/slave model turns SCL/SDA into frames,
// and each scenario compares counts, frames and pins against hand-computed values.
module tb_sccb_cfg_seq;

`ifdef SCCB_ACK_CHECK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic       CLOCK  = 1'b0;
  logic       RESET  = 1'b1;
  logic       START  = 1'b0;
  logic       start1 = 1'b0;
  logic [7:0] tbl_idx, tbl_addr, tbl_data;
  logic       scl, sda_oe, sda_i, busy, done, error;
  logic [7:0] tbl_idx1;
  logic [7:0] tbl_addr1, tbl_data1;
  logic       scl1, sda_oe1, sda1_i, busy1, done1, error1;
  logic       sda_line;
  logic       slave_drv = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLOCK = ~CLOCK;

  assign tbl_addr  = (tbl_idx == 8'd0) ? 8'h12 : 8'h11;
  assign tbl_data  = (tbl_idx == 8'd0) ? 8'h80 : 8'h01;
  assign tbl_addr1 = 8'h3A;
  assign tbl_data1 = 8'h5C;
  assign sda_line  = ~sda_oe & ~slave_drv;
  assign sda_i     = ACK_EN ? sda_line : 1'b1;
  assign sda1_i    = ACK_EN ? 1'b0 : 1'b1;

  sccb_cfg_seq #(.CLK_DIV(4), .DEV_ADDR(8'h42), .NUM_REGS(2), .GAP_TICKS(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .TBL_IDX(tbl_idx),
    .TBL_ADDR(tbl_addr), .TBL_DATA(tbl_data), .SCL_O(scl), .SDA_OE(sda_oe),
    .SDA_I(sda_i), .BUSY(busy), .DONE(done), .ERROR(error)
  );

  sccb_cfg_seq #(.CLK_DIV(2), .DEV_ADDR(8'h42), .NUM_REGS(1), .GAP_TICKS(8)) dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .START(start1), .TBL_IDX(tbl_idx1),
    .TBL_ADDR(tbl_addr1), .TBL_DATA(tbl_data1), .SCL_O(scl1), .SDA_OE(sda_oe1),
    .SDA_I(sda1_i), .BUSY(busy1), .DONE(done1), .ERROR(error1)
  );

  // Bus monitor and slave: frames are {byte count, last three bytes}
  int          busy_cyc = 0, done_cnt = 0, stops = 0, idx_chg = 0, bitn = 0;
  int          nack_byte = -1;
  logic [31:0] frames[$];
  logic        scl_p = 1'b1, sda_p = 1'b1, in_frame = 1'b0;
  logic [7:0]  shreg = '0, nbytes = '0, idx_p = '0;
  logic [23:0] frame = '0;

  always @(negedge CLOCK) begin
    logic s;
    s = sda_line;
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (tbl_idx != idx_p) idx_chg++;
    idx_p = tbl_idx;
    if (scl && scl_p && sda_p && !s) begin
      in_frame = 1'b1; bitn = 0; nbytes = '0; frame = '0;
    end else if (scl && scl_p && !sda_p && s) begin
      if (in_frame) frames.push_back({nbytes, frame});
      stops++;
      in_frame = 1'b0;
    end else if (scl && !scl_p && in_frame) begin
      if (bitn < 8) begin
        shreg = {shreg[6:0], s};
        bitn++;
      end else begin
        frame  = {frame[15:0], shreg};
        nbytes = nbytes + 8'd1;
        bitn   = 0;
      end
    end
    if (!scl && scl_p)
      slave_drv = ACK_EN && in_frame && (bitn == 8) && (int'(nbytes) != nack_byte);
    scl_p = scl;
    sda_p = s;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int win(input int v, input int e, input int tol);
    return (v >= e - tol && v <= e + tol) ? e : v;
  endfunction

  function automatic logic [31:0] get_frame(input int i);
    if (i < frames.size()) return frames[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int base, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLOCK);
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0, d0, f0, i0, s0, cyc;
    bit ok;

    RESET = 1'b1;
    repeat (4) @(negedge CLOCK);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_idx", tbl_idx, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_d1_bus", {scl1, sda_oe1, busy1}, 3'b100);
    RESET = 1'b0;
    @(negedge CLOCK);

    // Two-entry run with a second START mid-run that must be ignored
    b0 = busy_cyc; d0 = done_cnt; f0 = frames.size(); i0 = idx_chg;
    pulse_start();
    chk("A_busy_rise", busy, 1'b1);
    chk("A_idx_first", tbl_idx, 8'd0);
    repeat (300) @(negedge CLOCK);
    pulse_start();
    wait_done(d0, 3000, ok);
    chk("A_done_seen", ok, 1'b1);
    repeat (10) @(negedge CLOCK);
    chk("A_busy_cycles", win(busy_cyc - b0, 968, 2), 968);
    chk("A_done_count", done_cnt - d0, 1);
    chk("A_frame_count", frames.size() - f0, 2);
    chk("A_frame0", get_frame(f0), 32'h0342_1280);
    chk("A_frame1", get_frame(f0 + 1), 32'h0342_1101);
    chk("A_idx_steps", idx_chg - i0, 1);
    chk("A_idx_final", tbl_idx, 8'd1);
    chk("A_error", error, 1'b0);
    chk("A_idle_bus", {scl, sda_oe}, 2'b10);

    // RESET and START together: reset wins
    RESET = 1'b1; START = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0; START = 1'b0;
    chk("RS_busy", busy, 1'b0);
    chk("RS_idx", tbl_idx, 8'd0);
    @(negedge CLOCK);
    chk("RS_busy_after", busy, 1'b0);

`ifdef SCCB_ACK_CHECK_EN
    // Slave NACKs the register-address byte of entry 0
    nack_byte = 1; d0 = done_cnt; s0 = stops; f0 = frames.size();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLOCK);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("N_abort", ok, 1'b1);
    repeat (5) @(negedge CLOCK);
    chk("N_error", error, 1'b1);
    chk("N_no_done", done_cnt - d0, 0);
    chk("N_idx", tbl_idx, 8'd0);
    chk("N_stop_seen", stops - s0, 1);
    chk("N_frame", get_frame(f0), 32'h0200_4212);
    nack_byte = -1; d0 = done_cnt;
    pulse_start();
    chk("N_error_clear", error, 1'b0);
    wait_done(d0, 3000, ok);
    chk("N_rerun_done", ok, 1'b1);
    repeat (5) @(negedge CLOCK);
`endif

    // Reset at tick 50 of the first write: abort with no STOP and no DONE
    d0 = done_cnt; s0 = stops;
    pulse_start();
    repeat (201) @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    chk("B_scl", scl, 1'b1);
    chk("B_sda_oe", sda_oe, 1'b0);
    chk("B_busy", busy, 1'b0);
    chk("B_idx", tbl_idx, 8'd0);
    repeat (300) @(negedge CLOCK);
    chk("B_no_done", done_cnt - d0, 0);
    chk("B_no_stop", stops - s0, 0);
    chk("B_still_idle", busy, 1'b0);

    // Fresh run after the abort restarts at entry 0
    d0 = done_cnt; f0 = frames.size();
    pulse_start();
    chk("B2_idx_first", tbl_idx, 8'd0);
    wait_done(d0, 3000, ok);
    chk("B2_done_seen", ok, 1'b1);
    repeat (5) @(negedge CLOCK);
    chk("B2_frame_count", frames.size() - f0, 2);
    chk("B2_frame0", get_frame(f0), 32'h0342_1280);

    // Single-entry instance, CLK_DIV=2: DONE 1+(113+8)*2 cycles after START
    start1 = 1'b1;
    @(negedge CLOCK);
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 1000) begin
      @(negedge CLOCK);
      cyc++;
    end
    chk("D1_done_latency", win(cyc, 243, 2), 243);
    @(negedge CLOCK);
    chk("D1_done_width", done1, 1'b0);
    chk("D1_busy", busy1, 1'b0);
    chk("D1_error", error1, 1'b0);
    chk("D1_idx", tbl_idx1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
